timer_status_ctrl: RTL and testbench

//  Consumer side of the 8-bit timer counter: watches cnt/last_cnt plus the counter controls.

---
 rtl/timer_pkg.sv | 14 +
 rtl/timer_flag_bit.sv | 18 +
 rtl/timer_status_ctrl.sv | 94 +++++++++
 tb/tb_timer_status_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared TSR bit map and register offsets for the timer status path and the APB register file.
package timer_pkg;

    localparam int TSR_OVF_BIT = 0;
    localparam int TSR_UDF_BIT = 1;
    localparam int TSR_CMP_BIT = 2;
    localparam int TSR_W       = 3;

    typedef enum logic [7:0] {
        REG_TSR  = 8'h08,
        REG_TIER = 8'h0C
    } timer_reg_e;

endpackage

// File: rtl/timer_flag_bit.sv
// Sticky status bit: a set in the same cycle as a clear wins.
module timer_flag_bit (
    input  logic clk_in,
    input  logic presetn,
    input  logic set,
    input  logic clr,
    output logic q
);

    always_ff @(posedge clk_in) begin
        if (!presetn) begin
            q <= 1'b0;
        end else begin
            q <= set | (q & ~clr);
        end
    end

endmodule

// File: rtl/timer_status_ctrl.sv
// Timer status: wrap detection, sticky W1C TSR flags and the masked, registered interrupt.
// Build option TMR_CMP_MATCH_EN adds the compare-match flag on tsr[2].
module timer_status_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             presetn,
    input  logic             en,
    input  logic             load,
    input  logic             ud,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] last_cnt,
    input  logic [WIDTH-1:0] tcmp,
    input  logic             tsr_wr,
    input  logic [2:0]       tsr_wdata,
    input  logic [2:0]       tier,
    output logic [2:0]       tsr,
    output logic             tmr_irq
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic             en_d;
    logic             load_d;
    logic             ud_d;
    logic             ovf_evt;
    logic             udf_evt;
    logic [TSR_W-1:0] clr;

    // Stage 1: controls aligned with the cnt/last_cnt pair produced at the same edge
    always_ff @(posedge clk_in) begin
        if (!presetn) begin
            en_d   <= 1'b0;
            load_d <= 1'b0;
            ud_d   <= 1'b0;
        end else begin
            en_d   <= en;
            load_d <= load;
            ud_d   <= ud;
        end
    end

    assign ovf_evt = en_d & ~load_d & ~ud_d & (last_cnt == MAX) & (cnt == '0);
    assign udf_evt = en_d & ~load_d &  ud_d & (last_cnt == '0) & (cnt == MAX);
    assign clr     = {TSR_W{tsr_wr}} & tsr_wdata;

    timer_flag_bit u_ovf (
        .clk_in  (clk_in),
        .presetn (presetn),
        .set     (ovf_evt),
        .clr     (clr[TSR_OVF_BIT]),
        .q       (tsr[TSR_OVF_BIT])
    );

    timer_flag_bit u_udf (
        .clk_in  (clk_in),
        .presetn (presetn),
        .set     (udf_evt),
        .clr     (clr[TSR_UDF_BIT]),
        .q       (tsr[TSR_UDF_BIT])
    );

`ifdef TMR_CMP_MATCH_EN
    logic cmp_evt;

    // Fires on arrival only, so a counter halted on tcmp does not re-set the flag
    assign cmp_evt = ~load_d & (cnt == tcmp) & (cnt != last_cnt);

    timer_flag_bit u_cmp (
        .clk_in  (clk_in),
        .presetn (presetn),
        .set     (cmp_evt),
        .clr     (clr[TSR_CMP_BIT]),
        .q       (tsr[TSR_CMP_BIT])
    );
`else
    logic unused_cmp;

    assign tsr[TSR_CMP_BIT] = 1'b0;
    assign unused_cmp       = ^{tcmp, clr[TSR_CMP_BIT]};
`endif

    // Stage 2: interrupt from the flags as they stand before this edge's update
    always_ff @(posedge clk_in) begin
        if (!presetn) begin
            tmr_irq <= 1'b0;
        end else begin
            tmr_irq <= |(tsr & tier);
        end
    end

endmodule

// File: tb/tb_timer_status_ctrl.sv
// Bench for timer_status_ctrl: drives a behavioural counter and scores flags/irq per cycle.
module tb_timer_status_ctrl;

    localparam int WIDTH = 8;
`ifdef TMR_CMP_MATCH_EN
    localparam logic [2:0] IMPL = 3'b111;
`else
    localparam logic [2:0] IMPL = 3'b011;
`endif

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic             presetn, en, load, ud, tsr_wr, tmr_irq;
    logic [WIDTH-1:0] cnt, last_cnt, tcmp, tdr;
    logic [2:0]       tsr_wdata, tier, tsr;

    timer_status_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_in    (clk_in),
        .presetn   (presetn),
        .en        (en),
        .load      (load),
        .ud        (ud),
        .cnt       (cnt),
        .last_cnt  (last_cnt),
        .tcmp      (tcmp),
        .tsr_wr    (tsr_wr),
        .tsr_wdata (tsr_wdata),
        .tier      (tier),
        .tsr       (tsr),
        .tmr_irq   (tmr_irq)
    );

    typedef struct packed {
        logic [2:0] tsr;
        logic       irq;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         errors = 0;
    int         checks = 0;
    logic [2:0] m_tsr  = 3'b000;
    logic [2:0] m_pend = 3'b000;
    logic       m_irq  = 1'b0;

    // One clock: the counter reacts to the controls present at the edge, the model predicts flags/irq
    task automatic step();
        logic [WIDTH-1:0] nxt;
        logic [2:0]       np;
        exp_t             x;
        @(posedge clk_in);
        nxt = cnt;
        if (load) nxt = tdr;
        else if (en) nxt = ud ? cnt - 8'd1 : cnt + 8'd1;
        np    = 3'b000;
        np[0] = en & ~load & ~ud & (cnt == 8'hFF);
        np[1] = en & ~load &  ud & (cnt == 8'h00);
        np[2] = ~load & (nxt == tcmp) & (nxt != cnt);
        if (!presetn) begin
            m_tsr = 3'b000;
            m_irq = 1'b0;
            np    = {(nxt == tcmp) && (nxt != cnt), 2'b00};
        end else begin
            m_irq = |(m_tsr & tier);
            m_tsr = (m_pend | (m_tsr & ~({3{tsr_wr}} & tsr_wdata))) & IMPL;
        end
        m_pend = np & IMPL;
        #1;
        last_cnt = cnt;
        cnt      = nxt;
        x.tsr = m_tsr;
        x.irq = m_irq;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        presetn = 1'b0; en = 1'b0; load = 1'b0; ud = 1'b0;
        tsr_wr = 1'b0; tsr_wdata = 3'b000; tier = 3'b111;
        for (int i = 0; i < 2; i++) begin
            step();
            e = sb.pop_front();
            checks++;
            if (tsr !== 3'b000 || tmr_irq !== 1'b0) begin
                errors++;
                $display("FAIL reset: tsr=%b irq=%b, expected tsr=000 irq=0", tsr, tmr_irq);
            end
        end
        presetn = 1'b1;
    endtask

    task automatic test_overflow();
        logic saw_zero, irq_due;
        saw_zero = 1'b0; irq_due = 1'b0;
        tier = 3'b001; ud = 1'b0; tsr_wr = 1'b0; tdr = 8'hFD;
        for (int i = 0; i < 8; i++) begin
            presetn = (i != 0);
            en      = (i != 0);
            load    = (i == 1);
            step();
            e = sb.pop_front();
            checks++;
            if (tsr !== e.tsr || tmr_irq !== e.irq) begin
                errors++;
                $display("FAIL ovf_model cyc%0d: tsr=%b irq=%b, expected tsr=%b irq=%b", i, tsr, tmr_irq, e.tsr, e.irq);
            end
            if (irq_due) begin
                checks++;
                if (tmr_irq !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_irq cyc%0d: irq=%b, expected 1", i, tmr_irq);
                end
            end
            if (saw_zero) begin
                checks++;
                if (tsr[1:0] !== 2'b01 || tmr_irq !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_flag cyc%0d: tsr=%b irq=%b, expected tsr[1:0]=01 irq=0", i, tsr, tmr_irq);
                end
            end
            irq_due  = saw_zero;
            saw_zero = (i != 0) && (cnt == 8'h00);
        end
    endtask

    task automatic test_underflow();
        logic saw_max;
        saw_max = 1'b0;
        tier = 3'b010; ud = 1'b1; tsr_wr = 1'b0; tdr = 8'h02;
        for (int i = 0; i < 7; i++) begin
            presetn = (i != 0);
            en      = (i != 0);
            load    = (i == 1);
            step();
            e = sb.pop_front();
            checks++;
            if (tsr !== e.tsr || tmr_irq !== e.irq) begin
                errors++;
                $display("FAIL udf_model cyc%0d: tsr=%b irq=%b, expected tsr=%b irq=%b", i, tsr, tmr_irq, e.tsr, e.irq);
            end
            if (saw_max) begin
                checks++;
                if (tsr[1:0] !== 2'b10) begin
                    errors++;
                    $display("FAIL udf_flag cyc%0d: tsr=%b, expected tsr[1:0]=10", i, tsr);
                end
            end
            saw_max = (i != 0) && (cnt == 8'hFF);
        end
    endtask

    task automatic test_load_no_event();
        tier = 3'b011; tsr_wr = 1'b0; tsr_wdata = 3'b000;
        for (int i = 0; i < 9; i++) begin
            presetn = (i != 0);
            case (i)
                0: begin en = 1'b0; load = 1'b0; ud = 1'b0; end
                1: begin load = 1'b1; tdr = 8'hFF; end
                2: load = 1'b0;
                3: begin load = 1'b1; tdr = 8'h00; en = 1'b1; ud = 1'b0; end
                4: begin load = 1'b0; en = 1'b0; end
                5: begin load = 1'b1; tdr = 8'hFF; en = 1'b1; ud = 1'b1; end
                6: begin load = 1'b0; en = 1'b0; end
                default: ;
            endcase
            step();
            e = sb.pop_front();
            checks++;
            if (tsr !== e.tsr || tmr_irq !== e.irq) begin
                errors++;
                $display("FAIL load_model cyc%0d: tsr=%b irq=%b, expected tsr=%b irq=%b", i, tsr, tmr_irq, e.tsr, e.irq);
            end
            checks++;
            if (tsr !== 3'b000 || tmr_irq !== 1'b0) begin
                errors++;
                $display("FAIL load_no_event cyc%0d: tsr=%b irq=%b, expected tsr=000 irq=0", i, tsr, tmr_irq);
            end
        end
    endtask

    task automatic test_set_wins();
        logic [1:0] want [12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11,
                                  2'b11, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00};
        for (int i = 0; i < 12; i++) begin
            presetn = (i != 0);
            case (i)
                0:  begin en = 1'b0; load = 1'b0; ud = 1'b0; tsr_wr = 1'b0; tsr_wdata = 3'b000; tier = 3'b001; end
                1:  begin en = 1'b1; load = 1'b1; tdr = 8'hFE; end
                2:  load = 1'b0;
                5:  begin load = 1'b1; tdr = 8'hFF; tsr_wr = 1'b1; tsr_wdata = 3'b000; end
                6:  begin load = 1'b0; tsr_wr = 1'b0; end
                7:  begin tsr_wr = 1'b1; tsr_wdata = 3'b001; end
                8:  begin en = 1'b0; tsr_wr = 1'b0; tier = 3'b000; end
                9:  tier = 3'b001;
                10: begin tsr_wr = 1'b1; tsr_wdata = 3'b001; end
                11: tsr_wr = 1'b0;
                default: ;
            endcase
            step();
            e = sb.pop_front();
            checks++;
            if (tsr !== e.tsr || tmr_irq !== e.irq) begin
                errors++;
                $display("FAIL w1c_model cyc%0d: tsr=%b irq=%b, expected tsr=%b irq=%b", i, tsr, tmr_irq, e.tsr, e.irq);
            end
            checks++;
            if ({tsr[0], tmr_irq} !== want[i]) begin
                errors++;
                $display("FAIL set_wins cyc%0d: tsr0,irq=%b%b, expected %b", i, tsr[0], tmr_irq, want[i]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin presetn = 1'b0; en = 1'b0; load = 1'b0; ud = 1'b0; tsr_wr = 1'b0; tier = 3'b011; end
                1: begin presetn = 1'b1; en = 1'b1; load = 1'b1; tdr = 8'hFF; end
                2: load = 1'b0;
                3: ud = 1'b1;
                5: begin load = 1'b1; tdr = 8'h00; end
                6: begin load = 1'b0; presetn = 1'b0; end
                7: presetn = 1'b1;
                default: ;
            endcase
            step();
            e = sb.pop_front();
            checks++;
            if (tsr !== e.tsr || tmr_irq !== e.irq) begin
                errors++;
                $display("FAIL rst_model cyc%0d: tsr=%b irq=%b, expected tsr=%b irq=%b", i, tsr, tmr_irq, e.tsr, e.irq);
            end
            if (i == 4 || i == 5) begin
                checks++;
                if (tsr !== 3'b011 || (i == 5 && tmr_irq !== 1'b1)) begin
                    errors++;
                    $display("FAIL rst_pre cyc%0d: tsr=%b irq=%b, expected tsr=011", i, tsr, tmr_irq);
                end
            end
            if (i >= 6) begin
                checks++;
                if (tsr !== 3'b000 || tmr_irq !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_mid cyc%0d: tsr=%b irq=%b, expected tsr=000 irq=0", i, tsr, tmr_irq);
                end
            end
        end
    endtask

    task automatic test_cmp();
        logic w2;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0:  begin presetn = 1'b0; en = 1'b0; load = 1'b0; ud = 1'b0; tsr_wr = 1'b0;
                          tcmp = 8'h10; tier = 3'b100; end
                1:  begin presetn = 1'b1; en = 1'b1; load = 1'b1; tdr = 8'h0E; end
                2:  load = 1'b0;
                4:  en = 1'b0;
                6:  begin tsr_wr = 1'b1; tsr_wdata = 3'b100; end
                7:  tsr_wr = 1'b0;
                8:  begin load = 1'b1; tdr = 8'h05; end
                9:  tdr = 8'h10;
                10: load = 1'b0;
                default: ;
            endcase
            step();
            e = sb.pop_front();
            checks++;
            if (tsr !== e.tsr || tmr_irq !== e.irq) begin
                errors++;
                $display("FAIL cmp_model cyc%0d: tsr=%b irq=%b, expected tsr=%b irq=%b", i, tsr, tmr_irq, e.tsr, e.irq);
            end
            w2 = (i == 4 || i == 5) ? IMPL[2] : 1'b0;
            checks++;
            if (tsr[2] !== w2 || (i == 5 && tmr_irq !== IMPL[2])) begin
                errors++;
                $display("FAIL cmp_flag cyc%0d: tsr2=%b irq=%b, expected tsr2=%b", i, tsr[2], tmr_irq, w2);
            end
        end
    endtask

    initial begin
        presetn = 1'b0; en = 1'b0; load = 1'b0; ud = 1'b0;
        cnt = 8'h00; last_cnt = 8'h00; tcmp = 8'h80; tdr = 8'h00;
        tsr_wr = 1'b0; tsr_wdata = 3'b000; tier = 3'b000;
        test_reset();
        test_overflow();
        test_underflow();
        test_load_no_event();
        test_set_wins();
        test_reset_midrun();
        test_cmp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
